// File: rtl/axi_arbiter_pkg.sv
// Shared stream types for the channel arbiter and its demux counterpart.
// Widths track the globals header.
package axi_arbiter_pkg;

    localparam int DATA_SIZE  = 32;
    localparam int ID_SIZE    = 8;
    localparam int CHANNELS_W = 2;
    localparam int DROP_CNT_W = 16;

    typedef logic [CHANNELS_W-1:0] Channel;

    typedef struct packed {
        logic [DATA_SIZE-1:0] data;
        logic [ID_SIZE-1:0]   id;
        Channel               idx_channel;
    } axi_data_t;

    typedef enum logic [1:0] {
        IDLE,
        PASS,
        DROP
    } demux_state_t;

endpackage

// File: rtl/axi_demux_fifo2.sv
// Two-entry AXI-Stream skid buffer; head entry always sits in r_mem0.
// Accepts a push while full only if the head pops in the same cycle.
module axis_fifo2 #(
    parameter int W = 41
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    output logic         o_full,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_dout
);

    logic [W-1:0] r_mem0;
    logic [W-1:0] r_mem1;
    logic [1:0]   r_cnt;
    logic         w_pop;
    logic         w_push;

    assign o_valid = (r_cnt != 2'd0);
    assign o_full  = (r_cnt == 2'd2);
    assign o_dout  = r_mem0;
    assign w_pop   = o_valid && i_ready;
    assign w_push  = i_push && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 2'd0;
        end else begin
            case (r_cnt)
                2'd0: begin
                    if (w_push) begin
                        r_mem0 <= i_din;
                        r_cnt  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (w_push && w_pop) begin
                        r_mem0 <= i_din;
                    end else if (w_push) begin
                        r_mem1 <= i_din;
                        r_cnt  <= 2'd2;
                    end else if (w_pop) begin
                        r_cnt  <= 2'd0;
                    end
                end
                2'd2: begin
                    if (w_pop) begin
                        r_mem0 <= r_mem1;
                        if (w_push) begin
                            r_mem1 <= i_din;
                        end else begin
                            r_cnt <= 2'd1;
                        end
                    end
                end
                default: r_cnt <= 2'd0;
            endcase
        end
    end

endmodule

// File: rtl/axi_demux.sv
// Routes packets of the merged arbiter stream back to per-channel outputs,
// locking the destination on the first beat and dropping invalid tags.
module axi_demux #(
    parameter int DATA_SIZE  = 32,
    parameter int ID_SIZE    = 8,
    parameter int CHANNELS_W = 2,
    parameter int CHANNELS   = 4
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic                          s_t_valid,
    output logic                          s_t_ready,
    input  logic                          s_t_last,
    input  axi_arbiter_pkg::axi_data_t    s_t_data,
    output logic [CHANNELS-1:0]           m_t_valid,
    input  logic [CHANNELS-1:0]           m_t_ready,
    output logic [CHANNELS-1:0]           m_t_last,
    output logic [CHANNELS*DATA_SIZE-1:0] m_t_data,
    output logic [CHANNELS*ID_SIZE-1:0]   m_t_id,
    output logic [15:0]                   drop_cnt
);

    import axi_arbiter_pkg::*;

    localparam int NSLOT = 2 ** CHANNELS_W;
    localparam int FW    = DATA_SIZE + ID_SIZE + 1;
    localparam logic [CHANNELS_W:0] CH_LIM = (CHANNELS_W + 1)'(CHANNELS);

    demux_state_t          r_state;
    demux_state_t          w_next;
    logic [CHANNELS_W-1:0] r_dest;
    logic [DROP_CNT_W-1:0] r_drop_cnt;
    logic [CHANNELS_W-1:0] w_tag;
    logic [CHANNELS_W-1:0] w_target;
    logic                  w_tag_ok;
    logic                  w_accept;
    logic                  w_route;
    logic                  w_drop_done;
    logic                  w_load_dest;
    logic [NSLOT-1:0]      w_full_pad;
    logic [CHANNELS-1:0]   w_full;
    logic [CHANNELS-1:0]   w_push;
    logic [CHANNELS-1:0]   w_fvalid;
    logic [FW-1:0]         w_din;
    logic [FW-1:0]         w_dout [CHANNELS];

    assign w_tag      = s_t_data.idx_channel;
    assign w_tag_ok   = ({1'b0, w_tag} < CH_LIM);
    assign w_target   = (r_state == PASS) ? r_dest : w_tag;
    assign w_full_pad = NSLOT'(w_full);
    assign w_accept   = s_t_valid && s_t_ready;
    assign w_din      = {s_t_data.data, s_t_data.id, s_t_last};
    assign drop_cnt   = r_drop_cnt;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept && !s_t_last) begin
                    w_next = w_tag_ok ? PASS : DROP;
                end
            end
            PASS, DROP: begin
                if (w_accept && s_t_last) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Ready never looks at s_t_valid: only state, tag and buffer fullness.
    always_comb begin
        s_t_ready   = 1'b0;
        w_route     = 1'b0;
        w_drop_done = 1'b0;
        w_load_dest = 1'b0;
        if (!areset) begin
            unique case (r_state)
                IDLE: begin
                    s_t_ready   = w_tag_ok ? !w_full_pad[w_tag] : 1'b1;
                    w_route     = w_tag_ok;
                    w_drop_done = !w_tag_ok && s_t_last;
                    w_load_dest = w_tag_ok && !s_t_last;
                end
                PASS: begin
                    s_t_ready = !w_full_pad[r_dest];
                    w_route   = 1'b1;
                end
                DROP: begin
                    s_t_ready   = 1'b1;
                    w_drop_done = s_t_last;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_dest     <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_accept && w_load_dest) begin
                r_dest <= w_tag;
            end
            if (w_accept && w_drop_done && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_out
        assign w_push[g] = w_accept && w_route
                           && (w_target == CHANNELS_W'(g));

        axis_fifo2 #(
            .W (FW)
        ) u_fifo (
            .clk     (aclk),
            .rst     (areset),
            .i_push  (w_push[g]),
            .i_din   (w_din),
            .o_full  (w_full[g]),
            .o_valid (w_fvalid[g]),
            .i_ready (m_t_ready[g]),
            .o_dout  (w_dout[g])
        );

        assign m_t_valid[g] = w_fvalid[g] && !areset;
        assign m_t_last[g]  = w_dout[g][0];
        assign m_t_id[g*ID_SIZE +: ID_SIZE] = w_dout[g][ID_SIZE:1];
        assign m_t_data[g*DATA_SIZE +: DATA_SIZE] =
            w_dout[g][FW-1 -: DATA_SIZE];
    end

endmodule
